csi_rx_dly_cal: RTL and testbench
=================================

# csi_rx_dly_cal

Per-lane IDELAY calibration controller for the CSI-2 receive front end, running in the byte-clock domain. Sequentially sweeps each data lane's 5-bit input-delay tap through 0..31. At each tap it counts sync-detect pulses from that lane's byte aligner, finds the widest contiguous passing window, and programs the window centre into the data PHY. Sits between the byte aligners (hit source) and the per-lane data PHY delay inputs (tap sink), under control of the camera-enable / top-level sequencing logic.

## Interface
- NUM_LANE, 2, number of data lanes calibrated
- TAP_W, 5, delay tap width; sweep covers 0..2**TAP_W-1
- SETTLE_CYC, 8, cycles waited after each tap load before counting
- DWELL_CYC, 4096, cycles per tap during which hits are counted
- MIN_HITS, 4, hits required for a tap to pass
- MIN_EYE, 3, minimum passing-run length for lane success
- DEFAULT_TAP, 16, tap applied to a failed lane and after reset
- LOSS_CYC, 2**20, no-hit timeout for auto-recal (used only with macro)

Ports:
- clock, in, 1, byte clock
- reset_n, in, 1, reset: asynchronous assert, active-low
- enable, in, 1, camera enable; low aborts calibration
- start, in, 1, single-cycle calibration request
- sync_hit, in, NUM_LANE, per-lane sync-sequence detect pulse from the byte aligner
- delay_out, out, NUM_LANE*TAP_W, per-lane tap; lane i at [i*TAP_W +: TAP_W]
- delay_ld, out, NUM_LANE, one-cycle load strobe per lane
- busy, out, 1, calibration in progress
- done, out, 1, level; all lanes finished, held until next start or abort
- fail, out, NUM_LANE, lane found no eye ≥ MIN_EYE
- eye_len, out, NUM_LANE*(TAP_W+1), widest run length per lane

## Operation
- Reset values: delay_out = DEFAULT_TAP on all lanes; delay_ld, busy, done, fail, eye_len = 0; FSM in IDLE.
- States and transitions:
  - IDLE: on start && enable → SET with lane=0, tap=0; clear run trackers and this lane's fail/eye_len; done ← 0.
  - SET: drive delay_out[lane] = tap and pulse delay_ld[lane] → SETTLE.
  - SETTLE: wait SETTLE_CYC cycles → DWELL.
  - DWELL: count sync_hit[lane] over DWELL_CYC cycles. Counter saturates at MIN_HITS → EVAL.
  - EVAL: pass = (hits ≥ MIN_HITS).
    - On pass: extend the current run (open it at this tap if none is open).
    - On fail: close the run.
    - A closed run replaces best only if strictly longer; on ties the earlier run wins.
    - Tap 31 closes any open run. tap < max → SET with tap+1; otherwise → APPLY.
  - APPLY: if best_len < MIN_EYE, set fail[lane]=1 and tap=DEFAULT_TAP. Otherwise tap = best_start + (best_len >> 1), floor. Pulse delay_ld; eye_len[lane] ← best_len. Then go to SET for lane+1 (tap 0, trackers cleared), or to DONE after the last lane.
  - DONE: done=1, busy=0 → IDLE (done stays high).
- busy = 1 in every state except IDLE and DONE.
- start while busy: ignored.
- enable low in any busy state: → IDLE next cycle, with:
  - all delay_out = DEFAULT_TAP;
  - one delay_ld pulse on all lanes;
  - done = 0 and fail = 0.
- sync_hit on non-selected lanes is ignored.
- Lanes already applied keep their tap while later lanes sweep.

## Timing
- Cycles per tap: 1 (SET) + SETTLE_CYC + DWELL_CYC + 1 (EVAL).
- Per lane: 32 × that, plus 1 (APPLY).
- start → busy high: 1 cycle. Last APPLY → done high: 1 cycle.
- delay_out changes in the same cycle delay_ld is asserted, and is stable otherwise.
- Hits are counted only in DWELL, including the DWELL entry cycle and excluding the EVAL cycle.

## Configuration
- CSI_DLY_AUTORECAL_EN defined:
  - While done=1 and enable=1, a counter tracks cycles since the last sync_hit on any lane.
  - Reaching LOSS_CYC restarts calibration exactly as start does.
  - The counter resets on any hit and on start.
- Undefined: no counter; recalibration only via start.

## Structure
- Shared package: NUM_LANE, TAP_W, DEFAULT_TAP, the tap typedef (logic [TAP_W-1:0]), and the FSM state enum.
- One sub-module, csi_rx_eye_track. It holds the run tracker: inputs pass/valid/tap/clear; outputs best_start and best_len. It is reused per lane sequentially (single instance).

## Test plan
- Lane 0 hits only at taps 10..17 and lane 1 at 4..6, with DWELL_CYC=16 and 8 hits/tap → delay_out = {lane1=5, lane0=14}, eye_len = {3, 8}, fail = 0, done=1.
- Two windows on lane 0, 2..5 and 20..23, equal length → earlier wins, tap 4. Window 0..31 → tap 16, eye_len 32.
- No hits on lane 1 → fail[1]=1, delay_out lane1 = DEFAULT_TAP, lane 0 still calibrated, done=1.
- Lane 0 at exactly MIN_HITS-1 hits per tap everywhere → every tap fails, fail[0]=1. Lane 0 window of length 2 → fail[0]=1.
- enable dropped during lane 1 DWELL → next cycle IDLE, busy=0, done=0, all taps 16 with delay_ld=all-ones for 1 cycle. start while busy → no restart.
- With CSI_DLY_AUTORECAL_EN and LOSS_CYC=64: after done, 64 hit-free cycles → busy rises and a sweep restarts at tap 0. A hit at cycle 63 prevents the restart.

Source files
------------

// File: rtl/csi_rx_dly_cal_pkg.sv
// Shared types and sizing for the CSI-2 RX per-lane IDELAY calibration.
// Lane count, tap width and default tap live here so all files agree.
package csi_rx_dly_cal_pkg;

    localparam int NUM_LANE    = 2;
    localparam int TAP_W       = 5;
    localparam int DEFAULT_TAP = 16;
    localparam int TAP_MAX     = (2 ** TAP_W) - 1;
    localparam int EYE_W       = TAP_W + 1;
    localparam int LANE_W      = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;

    typedef logic [TAP_W-1:0] tap_t;
    typedef logic [EYE_W-1:0] eye_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET,
        S_SETTLE,
        S_DWELL,
        S_EVAL,
        S_APPLY,
        S_DONE
    } state_e;

    // Centre of a passing window, rounded down.
    function automatic tap_t eye_centre(tap_t start, eye_t len);
        return tap_t'(start + tap_t'(len >> 1));
    endfunction

endpackage

// File: rtl/csi_rx_eye_track.sv
// Widest-run tracker over a tap sweep; one instance shared by all lanes.
// Runs close on a failing tap or at the last tap; ties keep the earlier run.
module csi_rx_eye_track
    import csi_rx_dly_cal_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic valid_i,
    input  logic pass_i,
    input  tap_t tap_i,
    output tap_t best_start_o,
    output eye_t best_len_o
);

    tap_t run_start_q, run_start_d;
    eye_t run_len_q, run_len_d;
    tap_t best_start_q, best_start_d;
    eye_t best_len_q, best_len_d;
    eye_t cand_len;
    logic close;

    // Extend or close the current run and promote it when strictly longer.
    always_comb begin
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        cand_len     = run_len_q;
        close        = 1'b0;
        if (clear_i) begin
            run_start_d  = '0;
            run_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (valid_i) begin
            if (pass_i) begin
                if (run_len_q == '0) begin
                    run_start_d = tap_i;
                    run_len_d   = eye_t'(1);
                end else begin
                    run_len_d = run_len_q + eye_t'(1);
                end
                cand_len = run_len_d;
                close    = (tap_i == tap_t'(TAP_MAX));
            end else begin
                close = 1'b1;
            end
            if (close) begin
                if (cand_len > best_len_q) begin
                    best_start_d = run_start_d;
                    best_len_d   = cand_len;
                end
                run_len_d = '0;
            end
        end
    end

    // Tracker state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start_o = best_start_q;
    assign best_len_o   = best_len_q;

endmodule

// File: rtl/csi_rx_dly_cal.sv
// Per-lane IDELAY sweep/centre calibration in the byte-clock domain.
// Optional CSI_DLY_AUTORECAL_EN: recalibrate after LOSS_CYC hit-free cycles.
module csi_rx_dly_cal
    import csi_rx_dly_cal_pkg::*;
#(
    parameter int SETTLE_CYC = 8,
    parameter int DWELL_CYC  = 4096,
    parameter int MIN_HITS   = 4,
    parameter int MIN_EYE    = 3,
    parameter int LOSS_CYC   = 2 ** 20
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        start,
    input  logic [NUM_LANE-1:0]         sync_hit,
    output logic [NUM_LANE*TAP_W-1:0]   delay_out,
    output logic [NUM_LANE-1:0]         delay_ld,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_LANE-1:0]         fail,
    output logic [NUM_LANE*EYE_W-1:0]   eye_len
);

    localparam int CNT_MAX = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int HIT_W   = $clog2(MIN_HITS + 1);
    localparam int DLY_W   = NUM_LANE * TAP_W;
    localparam int EYL_W   = NUM_LANE * EYE_W;

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d, nxt_lane;
    tap_t                tap_q, tap_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HIT_W-1:0]    hits_q, hits_d;
    logic [DLY_W-1:0]    dly_q, dly_d;
    logic [NUM_LANE-1:0] ld_q, ld_d;
    logic                done_q, done_d;
    logic [NUM_LANE-1:0] fail_q, fail_d;
    logic [EYL_W-1:0]    eye_q, eye_d;

    logic                busy_w;
    logic                go;
    logic                trig;
    logic                pass;
    tap_t                apply_tap;
    tap_t                best_start;
    eye_t                best_len;

    assign busy_w   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign go       = (start && enable) || trig;
    assign pass     = (hits_q >= HIT_W'(MIN_HITS));
    assign nxt_lane = lane_q + LANE_W'(1);

    csi_rx_eye_track u_eye (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear_i      ((state_q == S_IDLE) || (state_q == S_APPLY)),
        .valid_i      (state_q == S_EVAL),
        .pass_i       (pass),
        .tap_i        (tap_q),
        .best_start_o (best_start),
        .best_len_o   (best_len)
    );

`ifdef CSI_DLY_AUTORECAL_EN
    localparam int LOSS_W = $clog2(LOSS_CYC + 1);

    logic [LOSS_W-1:0] loss_q, loss_d;

    // Count hit-free cycles while calibrated; fire a restart on expiry.
    always_comb begin
        loss_d = loss_q;
        trig   = 1'b0;
        if (!(done_q && enable) || (|sync_hit) || start) begin
            loss_d = '0;
        end else if (loss_q == LOSS_W'(LOSS_CYC - 1)) begin
            trig   = 1'b1;
            loss_d = '0;
        end else begin
            loss_d = loss_q + LOSS_W'(1);
        end
    end

    // Loss-of-sync counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end
`else
    logic unused_loss;

    assign trig        = 1'b0;
    assign unused_loss = (LOSS_CYC == 0);
`endif

    // Sweep sequencing, tap programming and abort handling.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        tap_d     = tap_q;
        cnt_d     = cnt_q;
        hits_d    = hits_q;
        dly_d     = dly_q;
        ld_d      = '0;
        done_d    = done_q;
        fail_d    = fail_q;
        eye_d     = eye_q;
        apply_tap = tap_t'(DEFAULT_TAP);
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d          = S_SET;
                    lane_d           = '0;
                    tap_d            = '0;
                    done_d           = 1'b0;
                    fail_d[0]        = 1'b0;
                    eye_d[0 +: EYE_W] = '0;
                end
            end
            S_SET: begin
                dly_d[lane_q*TAP_W +: TAP_W] = tap_q;
                ld_d[lane_q] = 1'b1;
                cnt_d        = '0;
                hits_d       = '0;
                state_d      = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DWELL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DWELL: begin
                if (sync_hit[lane_q] && (hits_q < HIT_W'(MIN_HITS))) begin
                    hits_d = hits_q + HIT_W'(1);
                end
                if (cnt_q == CNT_W'(DWELL_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_EVAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EVAL: begin
                if (tap_q == tap_t'(TAP_MAX)) begin
                    state_d = S_APPLY;
                end else begin
                    tap_d   = tap_q + tap_t'(1);
                    state_d = S_SET;
                end
            end
            S_APPLY: begin
                if (best_len < eye_t'(MIN_EYE)) begin
                    fail_d[lane_q] = 1'b1;
                    apply_tap      = tap_t'(DEFAULT_TAP);
                end else begin
                    apply_tap = eye_centre(best_start, best_len);
                end
                dly_d[lane_q*TAP_W +: TAP_W] = apply_tap;
                eye_d[lane_q*EYE_W +: EYE_W] = best_len;
                ld_d[lane_q] = 1'b1;
                if (lane_q == LANE_W'(NUM_LANE - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    lane_d           = nxt_lane;
                    tap_d            = '0;
                    fail_d[nxt_lane] = 1'b0;
                    eye_d[nxt_lane*EYE_W +: EYE_W] = '0;
                    state_d          = S_SET;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (busy_w && !enable) begin
            state_d = S_IDLE;
            dly_d   = {NUM_LANE{tap_t'(DEFAULT_TAP)}};
            ld_d    = '1;
            done_d  = 1'b0;
            fail_d  = '0;
        end
    end

    // Controller state and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            tap_q   <= '0;
            cnt_q   <= '0;
            hits_q  <= '0;
            dly_q   <= {NUM_LANE{tap_t'(DEFAULT_TAP)}};
            ld_q    <= '0;
            done_q  <= 1'b0;
            fail_q  <= '0;
            eye_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
            hits_q  <= hits_d;
            dly_q   <= dly_d;
            ld_q    <= ld_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            eye_q   <= eye_d;
        end
    end

    assign delay_out = dly_q;
    assign delay_ld  = ld_q;
    assign busy      = busy_w;
    assign done      = done_q;
    assign fail      = fail_q;
    assign eye_len   = eye_q;

endmodule

// File: tb/tb_csi_rx_dly_cal.sv
// Directed bench for csi_rx_dly_cal with short dwell (16) and LOSS_CYC=64.
// Hit sources are per-lane tap windows with fixed hit densities.
module tb_csi_rx_dly_cal;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        start;
    logic [1:0]  sync_hit;
    logic [9:0]  delay_out;
    logic [1:0]  delay_ld;
    logic        busy;
    logic        done;
    logic [1:0]  fail;
    logic [11:0] eye_len;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    bit [31:0] win [2];
    bit        mode [2];

    csi_rx_dly_cal #(
        .SETTLE_CYC (8),
        .DWELL_CYC  (16),
        .MIN_HITS   (4),
        .MIN_EYE    (3),
        .LOSS_CYC   (64)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .start     (start),
        .sync_hit  (sync_hit),
        .delay_out (delay_out),
        .delay_ld  (delay_ld),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .eye_len   (eye_len)
    );

    always #5 clock = ~clock;

    function automatic bit [31:0] span(int lo, int hi);
        bit [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // mode 0: 8 hits per 16-cycle dwell; mode 1: exactly 3 hits per dwell
    task automatic drive_hits();
        for (int l = 0; l < 2; l++) begin
            logic [4:0] t;
            bit         ph;
            t  = delay_out[l*5 +: 5];
            ph = mode[l] ? ((cyc % 16) < 3) : ((cyc % 2) == 0);
            sync_hit[l] = win[l][t] && ph;
        end
        cyc++;
    endtask

    task automatic run_cal(input string name);
        bit ok;
        ok = 1'b0;
        @(negedge clock);
        start = 1'b1;
        drive_hits();
        @(negedge clock);
        start = 1'b0;
        drive_hits();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            drive_hits();
        end
        sync_hit = '0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s done_timeout: got 0 want 1", name);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        enable   = 1'b0;
        start    = 1'b0;
        sync_hit = '0;
        win[0]   = '0;
        win[1]   = '0;
        mode[0]  = 1'b0;
        mode[1]  = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if (delay_out !== 10'h210) begin
            miscompares++;
            $display("FAIL reset_delay: got %h want 210", delay_out);
        end
        vectors++;
        if ({delay_ld, busy, done, fail} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000000",
                     {delay_ld, busy, done, fail});
        end
        vectors++;
        if (eye_len !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_eye: got %h want 000", eye_len);
        end
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (2) @(negedge clock);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_start: got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        win[0]  = span(10, 17);
        win[1]  = span(4, 6);
        mode[0] = 1'b0;
        mode[1] = 1'b0;
        run_cal("basic");
        vectors++;
        if (delay_out !== {5'd5, 5'd14}) begin
            miscompares++;
            $display("FAIL basic_delay: got %h want %h", delay_out, {5'd5, 5'd14});
        end
        vectors++;
        if (eye_len !== {6'd3, 6'd8}) begin
            miscompares++;
            $display("FAIL basic_eye: got %h want %h", eye_len, {6'd3, 6'd8});
        end
        vectors++;
        if ({fail, busy, done} !== 4'b0001) begin
            miscompares++;
            $display("FAIL basic_status: got %b want 0001", {fail, busy, done});
        end
    endtask

    task automatic test_two_windows();
        win[0] = span(2, 5) | span(20, 23);
        win[1] = span(0, 31);
        run_cal("two_win");
        vectors++;
        if (delay_out !== {5'd16, 5'd4}) begin
            miscompares++;
            $display("FAIL two_win_delay: got %h want %h", delay_out, {5'd16, 5'd4});
        end
        vectors++;
        if (eye_len !== {6'd32, 6'd4}) begin
            miscompares++;
            $display("FAIL two_win_eye: got %h want %h", eye_len, {6'd32, 6'd4});
        end
        vectors++;
        if ({fail, done} !== 3'b001) begin
            miscompares++;
            $display("FAIL two_win_status: got %b want 001", {fail, done});
        end
    endtask

    task automatic test_no_hits();
        win[0] = span(25, 31);
        win[1] = '0;
        run_cal("no_hits");
        vectors++;
        if (delay_out !== {5'd16, 5'd28}) begin
            miscompares++;
            $display("FAIL no_hits_delay: got %h want %h", delay_out, {5'd16, 5'd28});
        end
        vectors++;
        if (eye_len !== {6'd0, 6'd7}) begin
            miscompares++;
            $display("FAIL no_hits_eye: got %h want %h", eye_len, {6'd0, 6'd7});
        end
        vectors++;
        if ({fail, done} !== 3'b101) begin
            miscompares++;
            $display("FAIL no_hits_status: got %b want 101", {fail, done});
        end
    endtask

    task automatic test_weak_hits();
        win[0]  = span(0, 31);
        win[1]  = span(0, 31);
        mode[0] = 1'b1;
        run_cal("weak");
        mode[0] = 1'b0;
        vectors++;
        if (delay_out !== {5'd16, 5'd16}) begin
            miscompares++;
            $display("FAIL weak_delay: got %h want %h", delay_out, {5'd16, 5'd16});
        end
        vectors++;
        if (eye_len !== {6'd32, 6'd0}) begin
            miscompares++;
            $display("FAIL weak_eye: got %h want %h", eye_len, {6'd32, 6'd0});
        end
        vectors++;
        if ({fail, done} !== 3'b011) begin
            miscompares++;
            $display("FAIL weak_status: got %b want 011", {fail, done});
        end
    endtask

    task automatic test_narrow_eye();
        win[0] = span(7, 8);
        win[1] = '0;
        run_cal("narrow");
        vectors++;
        if (delay_out !== {5'd16, 5'd16}) begin
            miscompares++;
            $display("FAIL narrow_delay: got %h want %h", delay_out, {5'd16, 5'd16});
        end
        vectors++;
        if (eye_len !== {6'd0, 6'd2}) begin
            miscompares++;
            $display("FAIL narrow_eye: got %h want %h", eye_len, {6'd0, 6'd2});
        end
        vectors++;
        if ({fail, done} !== 3'b111) begin
            miscompares++;
            $display("FAIL narrow_status: got %b want 111", {fail, done});
        end
    endtask

    task automatic test_busy_start_abort();
        logic [4:0] t0;
        bit         found;
        win[0] = span(10, 17);
        win[1] = span(4, 6);
        @(negedge clock);
        start = 1'b1;
        drive_hits();
        @(negedge clock);
        start = 1'b0;
        drive_hits();
        repeat (200) begin
            @(negedge clock);
            drive_hits();
        end
        t0    = delay_out[4:0];
        start = 1'b1;
        drive_hits();
        @(negedge clock);
        start = 1'b0;
        drive_hits();
        repeat (3) begin
            @(negedge clock);
            drive_hits();
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_busy_busy: got %b want 1", busy);
        end
        vectors++;
        if (delay_out[4:0] < t0) begin
            miscompares++;
            $display("FAIL start_busy_tap: got %0d want >= %0d", delay_out[4:0], t0);
        end
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (delay_ld[1] === 1'b1) begin
                found = 1'b1;
                break;
            end
            drive_hits();
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL lane1_ld_timeout: got 0 want 1");
        end
        repeat (12) begin
            @(negedge clock);
            drive_hits();
        end
        vectors++;
        if (delay_out[4:0] !== 5'd14) begin
            miscompares++;
            $display("FAIL lane0_hold: got %0d want 14", delay_out[4:0]);
        end
        @(negedge clock);
        enable = 1'b0;
        @(posedge clock);
        #1;
        vectors++;
        if ({busy, done, fail} !== 4'b0000) begin
            miscompares++;
            $display("FAIL abort_status: got %b want 0000", {busy, done, fail});
        end
        vectors++;
        if (delay_out !== 10'h210) begin
            miscompares++;
            $display("FAIL abort_delay: got %h want 210", delay_out);
        end
        vectors++;
        if (delay_ld !== 2'b11) begin
            miscompares++;
            $display("FAIL abort_ld: got %b want 11", delay_ld);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (delay_ld !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_ld_once: got %b want 00", delay_ld);
        end
        @(negedge clock);
        sync_hit = '0;
        enable   = 1'b1;
    endtask

`ifdef CSI_DLY_AUTORECAL_EN
    task automatic test_autorecal();
        bit early;
        bit seen;
        win[0] = span(10, 17);
        win[1] = span(4, 6);
        run_cal("recal_base");
        early = 1'b0;
        repeat (62) begin
            @(negedge clock);
            if (busy !== 1'b0) early = 1'b1;
        end
        sync_hit = 2'b10;
        @(negedge clock);
        sync_hit = 2'b00;
        repeat (50) begin
            @(negedge clock);
            if (busy !== 1'b0) early = 1'b1;
        end
        vectors++;
        if (early) begin
            miscompares++;
            $display("FAIL recal_hit_blocks: got busy 1 want 0");
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (busy === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL recal_restart: got busy 0 want 1");
        end
        @(negedge clock);
        vectors++;
        if ({delay_out[4:0], delay_ld} !== 7'b00000_01) begin
            miscompares++;
            $display("FAIL recal_tap0: got %b want 0000001",
                     {delay_out[4:0], delay_ld});
        end
        enable = 1'b0;
        @(negedge clock);
        enable = 1'b1;
    endtask
`else
    task automatic test_autorecal();
        bit bad;
        win[0] = span(10, 17);
        win[1] = span(4, 6);
        run_cal("no_recal_base");
        bad = 1'b0;
        repeat (200) begin
            @(negedge clock);
            if (busy !== 1'b0 || done !== 1'b1) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL no_recal: got busy %b done %b want 0 1", busy, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_two_windows();
        test_no_hits();
        test_weak_hits();
        test_narrow_eye();
        test_busy_start_abort();
        test_autorecal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
